vga_fb_write_arbiter: RTL and testbench
=======================================

// Module: vga_fb_write_arbiter
// PURPOSE
//  Shares the single-port frame-buffer RAM between the display read path and two
//  write requesters (A, B). Write bursts are scheduled only inside blanking windows,
//  driven by hcount/vcount from the VGA timing generator (1344x806 frame, 1024x768 active).
//  Round-robin between A and B; a burst always finishes before active video resumes.
// PARAMETERS
//  H_ACTIVE   1024  visible pixels per line
//  H_TOTAL    1344  total clocks per line
//  V_ACTIVE   768   visible lines per frame
//  V_TOTAL    806   total lines per frame
//  MAX_BURST  16    max granted cycles per burst (1..H_TOTAL-H_ACTIVE-1)
//  ADDR_W     20    frame-buffer address width
//  DATA_W     12    pixel width (RGB444)
// PORTS
//  clk        in   1       pixel clock
//  rst_n      in   1       synchronous reset, active low
//  hcount     in   11      horizontal count from timing generator
//  vcount     in   11      vertical count from timing generator
//  disp_addr  in   ADDR_W  display read address
//  a_req      in   1       requester A wants to write; held for the whole burst
//  a_addr     in   ADDR_W  A write address
//  a_wdata    in   DATA_W  A write data
//  a_gnt      out  1       A owns the RAM this cycle
//  b_req, b_addr, b_wdata, b_gnt    same as A, for requester B
//  mem_addr   out  ADDR_W  RAM address
//  mem_we     out  1       RAM write enable
//  mem_wdata  out  DATA_W  RAM write data
//  disp_own   out  1       display owns the RAM (= !a_gnt && !b_gnt)
// BEHAVIOUR
//  - win_open (comb) = (vcount>=V_ACTIVE && vcount<=V_TOTAL-2)
//      || (hcount>=H_ACTIVE && hcount<=H_TOTAL-1-MAX_BURST).
//  - FSM, registered: IDLE, BURST_A, BURST_B, GAP. a_gnt = (state==BURST_A), b_gnt likewise.
//  - IDLE: if win_open and a request is pending -> BURST_x next cycle, beat_cnt<=0.
//    Only one request -> grant it. Both -> grant the one not served last (last_b flag).
//    No request or !win_open -> stay IDLE.
//  - BURST_x: beat_cnt increments every cycle. -> GAP when !x_req (that cycle not a beat)
//    or beat_cnt==MAX_BURST-1. last_b updated on exit (1 after B, 0 after A).
//  - GAP: exactly one cycle, no grant, disp_own=1; -> IDLE.
//  - Latency: request seen in IDLE at count h -> gnt high from h+1; at most MAX_BURST
//    gnt cycles, last one at hcount<=H_TOTAL-1; vblank bursts may cross into the next
//    line, which is still blank.
//  - mem_addr/mem_wdata: comb mux by gnt (A, B, else disp_addr / 0).
//    mem_we = (a_gnt&&a_req)||(b_gnt&&b_req); a beat is a cycle with mem_we=1.
//  - a_gnt and b_gnt are never both high. A request never starts in active video.
//  - Request dropped in IDLE before grant: no grant, no state change.
//  - Reset (rst_n=0 at posedge, any state incl. mid-burst): state=IDLE, beat_cnt=0,
//    last_b=1 (A wins first tie), a_gnt=b_gnt=0, mem_we=0, disp_own=1.
//    An aborted burst is not resumed.
// TESTING
//  1. a_req during active (v=10,h=100) -> no gnt until the IDLE sample at h=1024;
//     a_gnt h=1025..1040 (16 cycles), 16 mem_we pulses with a_addr/a_wdata on the RAM.
//  2. a_req rises at v=5,h=1330 (>1327) -> no grant on that line; a_gnt from v=6,h=1025.
//  3. a_req and b_req held during v=780 -> A 16 cycles, 1 GAP, IDLE, B 16 cycles, GAP,
//     IDLE, A ...; gnts never overlap; disp_own=1 in every GAP/IDLE cycle.
//  4. A granted in vblank, a_req dropped after 5 beats -> a_gnt low the cycle after
//     a_req is seen low; exactly 5 writes; B pending -> b_gnt 2 cycles later.
//  5. req at v=805,h=1320 -> no grant (1320>1327 false for hblank? no: 1320<=1327 ->
//     granted, last gnt at h=1336 <= 1343); req at v=805,h=1330 -> waits for v=0,h=1024.
//  6. rst_n=0 for one cycle mid BURST_B -> next cycle b_gnt=0, mem_we=0, disp_own=1;
//     with both reqs pending, the next grant goes to A.

Source files
------------

// File: rtl/vga_fb_write_arbiter.sv
// vga_fb_write_arbiter: round-robin A/B frame-buffer write bursts confined to blanking, display owns RAM otherwise
module vga_fb_write_arbiter #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_TOTAL   = 1344,
  parameter int V_ACTIVE  = 768,
  parameter int V_TOTAL   = 806,
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              disp_own
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [10:0] V_LO = 11'(V_ACTIVE);
  localparam logic [10:0] V_HI = 11'(V_TOTAL - 2);
  localparam logic [10:0] H_LO = 11'(H_ACTIVE);
  localparam logic [10:0] H_HI = 11'(H_TOTAL - 1 - MAX_BURST);
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);
  typedef enum logic [1:0] {IDLE, BURST_A, BURST_B, GAP} state_t;
  state_t state;
  logic [BW-1:0] beat_cnt;
  logic last_b;
  logic win_open;
  assign win_open = (vcount >= V_LO && vcount <= V_HI) || (hcount >= H_LO && hcount <= H_HI);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last_b   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (win_open && (a_req || b_req)) begin
          state    <= (a_req && (!b_req || last_b)) ? BURST_A : BURST_B;
          beat_cnt <= '0;
        end
        BURST_A: begin
          beat_cnt <= beat_cnt + 1'b1;
          if (!a_req || beat_cnt == LAST) begin
            state  <= GAP;
            last_b <= 1'b0;
          end
        end
        BURST_B: begin
          beat_cnt <= beat_cnt + 1'b1;
          if (!b_req || beat_cnt == LAST) begin
            state  <= GAP;
            last_b <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign a_gnt     = state == BURST_A;
  assign b_gnt     = state == BURST_B;
  assign disp_own  = !a_gnt && !b_gnt;
  assign mem_we    = (a_gnt && a_req) || (b_gnt && b_req);
  assign mem_addr  = a_gnt ? a_addr : b_gnt ? b_addr : disp_addr;
  assign mem_wdata = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// tb_vga_fb_write_arbiter: directed vectors and burst sequences for the frame-buffer write arbiter
module tb_vga_fb_write_arbiter;
  localparam logic [19:0] A_ADDR = 20'hA1234;
  localparam logic [19:0] B_ADDR = 20'hB5678;
  localparam logic [19:0] D_ADDR = 20'h0D15E;
  localparam logic [11:0] A_WD = 12'hA5A;
  localparam logic [11:0] B_WD = 12'hB0B;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic [19:0] disp_addr = D_ADDR;
  logic [19:0] a_addr = A_ADDR;
  logic [19:0] b_addr = B_ADDR;
  logic [11:0] a_wdata = A_WD;
  logic [11:0] b_wdata = B_WD;
  logic a_req = 1'b0;
  logic b_req = 1'b0;
  logic a_gnt, b_gnt, mem_we, disp_own;
  logic [19:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [35:0] bus;
  int checks = 0;
  int errors = 0;
  int h = 0;
  int v = 0;
  vga_fb_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .disp_addr(disp_addr),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .disp_own(disp_own)
  );
  assign bus = {a_gnt, b_gnt, mem_we, disp_own, mem_addr, mem_wdata};
  always #5 clk = ~clk;
  typedef struct {int v; int h; logic ar; logic br; logic ea; logic eb;} vec_t;
  vec_t tbl[15];
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (v=%0d h=%0d)", nm, got, exp, v, h);
    end
  endtask
  function automatic logic [35:0] exp_bus(input logic ea, input logic eb, input logic ar, input logic br);
    return {ea, eb, (ea && ar) || (eb && br), !(ea || eb),
            ea ? A_ADDR : (eb ? B_ADDR : D_ADDR), ea ? A_WD : (eb ? B_WD : 12'h0)};
  endfunction
  task automatic goto(input int vv, input int hh);
    v = vv;
    h = hh;
    hcount = 11'(hh);
    vcount = 11'(vv);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    h++;
    if (h == 1344) begin
      h = 0;
      v = (v == 805) ? 0 : v + 1;
    end
    hcount = 11'(h);
    vcount = 11'(v);
  endtask
  task automatic drive(input logic ar, input logic br);
    a_req = ar;
    b_req = br;
    #1;
  endtask
  task automatic do_reset();
    a_req = 1'b0;
    b_req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset", bus, exp_bus(1'b0, 1'b0, 1'b0, 1'b0));
  endtask
  initial begin
    int cnt, wcnt, bcnt, first, last, m;
    tbl[0]  = '{10, 100, 1, 0, 0, 0};
    tbl[1]  = '{10, 1023, 1, 0, 0, 0};
    tbl[2]  = '{10, 1024, 1, 0, 1, 0};
    tbl[3]  = '{10, 1327, 1, 0, 1, 0};
    tbl[4]  = '{10, 1328, 1, 0, 0, 0};
    tbl[5]  = '{767, 500, 1, 0, 0, 0};
    tbl[6]  = '{768, 0, 1, 0, 1, 0};
    tbl[7]  = '{804, 500, 1, 0, 1, 0};
    tbl[8]  = '{805, 500, 1, 0, 0, 0};
    tbl[9]  = '{805, 1320, 1, 0, 1, 0};
    tbl[10] = '{805, 1330, 1, 0, 0, 0};
    tbl[11] = '{0, 1024, 0, 1, 0, 1};
    tbl[12] = '{780, 0, 0, 1, 0, 1};
    tbl[13] = '{780, 0, 1, 1, 1, 0};
    tbl[14] = '{780, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      do_reset();
      goto(tbl[i].v, tbl[i].h);
      drive(tbl[i].ar, tbl[i].br);
      check("vec_idle", bus, exp_bus(1'b0, 1'b0, tbl[i].ar, tbl[i].br));
      tick();
      drive(tbl[i].ar, tbl[i].br);
      check("vec_gnt", bus, exp_bus(tbl[i].ea, tbl[i].eb, tbl[i].ar, tbl[i].br));
      drive(1'b0, 1'b0);
    end
    do_reset();
    goto(10, 100);
    cnt = 0; wcnt = 0; bcnt = 0; first = -1; last = -1;
    while (!(v == 10 && h == 1100)) begin
      drive(h <= 1040, 1'b0);
      if (a_gnt) begin
        cnt++;
        if (first < 0) first = h;
        last = h;
      end
      if (b_gnt) bcnt++;
      if (mem_we) begin
        wcnt++;
        check("s1_wr", {mem_addr, mem_wdata}, {A_ADDR, A_WD});
      end
      tick();
    end
    check("s1_first", first, 1025);
    check("s1_last", last, 1040);
    check("s1_gnt_cnt", cnt, 16);
    check("s1_we_cnt", wcnt, 16);
    check("s1_no_b", bcnt, 0);
    do_reset();
    goto(5, 1330);
    cnt = 0; first = -1;
    while (!(v == 6 && h == 1100)) begin
      drive(!(v == 6 && h > 1040), 1'b0);
      if (a_gnt) begin
        cnt++;
        if (first < 0) first = v * 2000 + h;
      end
      tick();
    end
    check("s2_first", first, 6 * 2000 + 1025);
    check("s2_gnt_cnt", cnt, 16);
    do_reset();
    goto(780, 0);
    for (int k = 0; k <= 60; k++) begin
      drive(1'b1, 1'b1);
      m = k % 36;
      check("s3_rr", bus, exp_bus(m >= 1 && m <= 16, m >= 19 && m <= 34, 1'b1, 1'b1));
      tick();
    end
    do_reset();
    goto(780, 0);
    wcnt = 0;
    for (int k = 0; k <= 14; k++) begin
      drive(k <= 5, 1'b1);
      check("s4_drop", bus, exp_bus(k >= 1 && k <= 6, k >= 9, k <= 5, 1'b1));
      if (mem_we && a_gnt) wcnt++;
      tick();
    end
    check("s4_a_writes", wcnt, 5);
    do_reset();
    goto(805, 1320);
    cnt = 0; first = -1; last = -1;
    for (int k = 0; k < 24; k++) begin
      drive(h <= 1336, 1'b0);
      if (a_gnt) begin
        cnt++;
        if (first < 0) first = h;
        last = h;
      end
      tick();
    end
    check("s5_first", first, 1321);
    check("s5_last", last, 1336);
    check("s5_gnt_cnt", cnt, 16);
    do_reset();
    goto(805, 1330);
    first = -1;
    while (!(v == 0 && h == 1030)) begin
      drive(1'b1, 1'b0);
      if (a_gnt && first < 0) first = v * 2000 + h;
      tick();
    end
    check("s5_wrap_first", first, 1025);
    do_reset();
    goto(780, 0);
    for (int k = 0; k <= 25; k++) begin
      drive(1'b1, 1'b1);
      m = k % 36;
      check("s6_pre", bus, exp_bus(m >= 1 && m <= 16, m >= 19 && m <= 34, 1'b1, 1'b1));
      if (k == 25) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b1);
    check("s6_abort", bus, exp_bus(1'b0, 1'b0, 1'b1, 1'b1));
    tick();
    drive(1'b1, 1'b1);
    check("s6_a_first", bus, exp_bus(1'b1, 1'b0, 1'b1, 1'b1));
    drive(1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
